sha256_nonce_dispatcher: RTL and testbench

Job scheduler that shares a pool of `simplified_sha256`-style hash engines across a nonce sweep for Bitcoin hashing. On `start` it issues `NUM_NONCES` consecutive nonces, beginning at `base_nonce`, to free engines in round-robin order. It tracks each engine through its start/done handshake and retires completions one per cycle. It sits between the top-level miner control and the replicated engine array; engines still own their memory traffic.

---
 rtl/sha256_nonce_dispatcher_if.sv | 22 ++
 rtl/sha256_nonce_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_sha256_nonce_dispatcher.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_nonce_dispatcher_if.sv
// Engine-array and completion bus between the nonce dispatcher and the replicated
// hash engines; the dispatcher owns the master side.
interface sha256_nonce_dispatcher_if #(
    parameter int unsigned NUM_ENGINES = 4
);
    logic [NUM_ENGINES-1:0]    eng_start;
    logic [32*NUM_ENGINES-1:0] eng_nonce;
    logic [NUM_ENGINES-1:0]    eng_done;
    logic                      cpl_valid;
    logic [3:0]                cpl_engine;
    logic [31:0]               cpl_nonce;

    modport master (
        output eng_start, eng_nonce, cpl_valid, cpl_engine, cpl_nonce,
        input  eng_done
    );

    modport slave (
        input  eng_start, eng_nonce, cpl_valid, cpl_engine, cpl_nonce,
        output eng_done
    );
endinterface

// File: rtl/sha256_nonce_dispatcher.sv
// Sweeps NUM_NONCES consecutive nonces across a pool of hash engines, dispatching
// round-robin to free engines and retiring one finished job per cycle.
module sha256_nonce_dispatcher #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned NUM_NONCES  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               base_nonce,
    sha256_nonce_dispatcher_if.master bus,
    output logic [15:0]               issued,
    output logic                      done
);
    localparam int unsigned IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic {S_IDLE, S_RUN} top_state_e;
    typedef enum logic [1:0] {E_FREE, E_ISSUED, E_WAIT_LOW, E_WAIT_HIGH} eng_state_e;

    top_state_e             state_q, state_d;
    eng_state_e             eng_q   [NUM_ENGINES];
    eng_state_e             eng_d   [NUM_ENGINES];
    logic [31:0]            nonce_q [NUM_ENGINES];
    logic [31:0]            nonce_d [NUM_ENGINES];
    logic [31:0]            base_q, base_d;
    logic [15:0]            issued_q, issued_d;
    logic [15:0]            retired_q, retired_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [IW-1:0]          disp_idx, ret_idx, scan_idx;
    logic                   disp_found, ret_found;
    int unsigned            scan_sum;
    logic [NUM_ENGINES-1:0] eng_start_q;
    logic                   cpl_valid_q, cpl_valid_d;
    logic [3:0]             cpl_engine_q, cpl_engine_d;
    logic [31:0]            cpl_nonce_q, cpl_nonce_d;
    logic                   done_q;

    always_comb begin
        state_d      = state_q;
        eng_d        = eng_q;
        nonce_d      = nonce_q;
        base_d       = base_q;
        issued_d     = issued_q;
        retired_d    = retired_q;
        rr_d         = rr_q;
        cpl_valid_d  = 1'b0;
        cpl_engine_d = cpl_engine_q;
        cpl_nonce_d  = cpl_nonce_q;
        disp_found   = 1'b0;
        disp_idx     = '0;
        ret_found    = 1'b0;
        ret_idx      = '0;
        scan_idx     = '0;
        scan_sum     = 0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    base_d    = base_nonce;
                    issued_d  = '0;
                    retired_d = '0;
                    rr_d      = '0;
                end
            end

            S_RUN: begin
                for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
                    case (eng_q[k])
                        E_ISSUED:   eng_d[k] = E_WAIT_LOW;
                        E_WAIT_LOW: if (!bus.eng_done[k]) eng_d[k] = E_WAIT_HIGH;
                        default:    ;
                    endcase
                end

                for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
                    if (!ret_found && eng_q[k] == E_WAIT_HIGH && bus.eng_done[k]) begin
                        ret_found = 1'b1;
                        ret_idx   = IW'(k);
                    end
                end
                if (ret_found) begin
                    eng_d[ret_idx] = E_FREE;
                    cpl_valid_d    = 1'b1;
                    cpl_engine_d   = 4'(ret_idx);
                    cpl_nonce_d    = nonce_q[ret_idx];
                    retired_d      = retired_q + 16'd1;
                end

                // Candidates come from the registered state, so an engine retiring
                // this cycle is still WAIT_HIGH here and cannot be re-dispatched.
                if (32'(issued_q) < NUM_NONCES) begin
                    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                        scan_sum = 32'(rr_q) + i;
                        if (scan_sum >= NUM_ENGINES) scan_sum = scan_sum - NUM_ENGINES;
                        scan_idx = IW'(scan_sum);
                        if (!disp_found && eng_q[scan_idx] == E_FREE && bus.eng_done[scan_idx]) begin
                            disp_found = 1'b1;
                            disp_idx   = scan_idx;
                        end
                    end
                end
                if (disp_found) begin
                    eng_d[disp_idx]   = E_ISSUED;
                    nonce_d[disp_idx] = base_q + 32'(issued_q);
                    issued_d          = issued_q + 16'd1;
                    rr_d              = (disp_idx == IW'(NUM_ENGINES - 1)) ? '0 : disp_idx + 1'b1;
                end

                // Uses the count registered by the previous retirement, so done
                // rises the cycle after the final completion pulse.
                if (32'(retired_q) == NUM_NONCES) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            issued_q     <= '0;
            retired_q    <= '0;
            rr_q         <= '0;
            eng_start_q  <= '0;
            cpl_valid_q  <= 1'b0;
            cpl_engine_q <= '0;
            cpl_nonce_q  <= '0;
            done_q       <= 1'b1;
            for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
                eng_q[k]   <= E_FREE;
                nonce_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issued_q     <= issued_d;
            retired_q    <= retired_d;
            rr_q         <= rr_d;
            cpl_valid_q  <= cpl_valid_d;
            cpl_engine_q <= cpl_engine_d;
            cpl_nonce_q  <= cpl_nonce_d;
            done_q       <= (state_d == S_IDLE);
            for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
                eng_q[k]       <= eng_d[k];
                nonce_q[k]     <= nonce_d[k];
                eng_start_q[k] <= (eng_d[k] == E_ISSUED);
            end
        end
    end

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_nonce_out
        assign bus.eng_nonce[32*g +: 32] = nonce_q[g];
    end

    assign bus.eng_start  = eng_start_q;
    assign bus.cpl_valid  = cpl_valid_q;
    assign bus.cpl_engine = cpl_engine_q;
    assign bus.cpl_nonce  = cpl_nonce_q;
    assign issued         = issued_q;
    assign done           = done_q;
endmodule

// File: tb/tb_sha256_nonce_dispatcher.sv
// Randomized scoreboard bench: behavioural engines feed expected completions, a
// separate monitor checks every dispatch and retirement the dispatcher presents.
module tb_sha256_nonce_dispatcher;
    localparam int unsigned NE = 4;
    localparam int unsigned NN = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_nonce;
    logic [15:0] issued;
    logic        done;

    sha256_nonce_dispatcher_if #(.NUM_ENGINES(NE)) bus ();

    sha256_nonce_dispatcher #(.NUM_ENGINES(NE), .NUM_NONCES(NN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_nonce (base_nonce),
        .bus        (bus),
        .issued     (issued),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int epoch = 0;
    int sweep = 0;
    int lat_cfg  [NE];
    int late_cfg [NE];
    logic [31:0] exp_disp [$];
    logic [31:0] exp_cpl  [NE][$];
    bit          busy     [NE];
    int          nret, ndisp, e_cyc;
    bit          first_disp_seen, last_prev;
    logic [31:0] cur_base;
    int          disp_eng [$];
    int          disp_cyc [$];
    int          cpl_eng  [$];
    int          cpl_cyc  [$];
    int          ret_cnt  [bit [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < NE; k++) begin
            lat_cfg[k]  = 0;
            late_cfg[k] = 0;
        end
    endtask

    // Behavioural engine: drops done after start, stays busy `lat` cycles, then
    // reports its nonce as an expected completion.
    task automatic engine_proc(input int k);
        int lat, late, ep, my_sweep;
        logic [31:0] n;
        my_sweep = -1;
        forever begin
            @(negedge clk);
            if (!reset && bus.eng_start[k]) begin
                n  = bus.eng_nonce[32*k +: 32];
                ep = epoch;
                lat  = int'($urandom_range(3, 12));
                late = 0;
                if (my_sweep != sweep) begin
                    my_sweep = sweep;
                    if (lat_cfg[k] != 0) lat = lat_cfg[k];
                    late = late_cfg[k];
                end
                @(posedge clk);
                repeat (late) @(posedge clk);
                #1 bus.eng_done[k] = 1'b0;
                repeat (lat) @(posedge clk);
                #1 bus.eng_done[k] = 1'b1;
                if (ep == epoch) exp_cpl[k].push_back(n);
            end
        end
    endtask

    task automatic monitor();
        int e;
        logic [31:0] n;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (last_prev) begin
                check("done_after_last_cpl", 32'(done), 32'd1);
                last_prev = 1'b0;
            end
            if (bus.eng_start != '0) begin
                check("one_start_per_cycle", $countones(bus.eng_start), 1);
                for (int k = 0; k < NE; k++) begin
                    if (bus.eng_start[k]) begin
                        check("dispatch_to_busy_engine", 32'(busy[k]), 32'd0);
                        if (exp_disp.size() == 0) fail_now("unexpected_dispatch", "no nonce left to issue");
                        else check("dispatch_nonce", bus.eng_nonce[32*k +: 32], exp_disp.pop_front());
                        busy[k] = 1'b1;
                        ndisp++;
                        disp_eng.push_back(k);
                        disp_cyc.push_back(cyc);
                        if (!first_disp_seen) begin
                            check("first_dispatch_latency", cyc, e_cyc + 1);
                            first_disp_seen = 1'b1;
                        end
                    end
                end
                check("issued_count", 32'(issued), ndisp);
            end
            if (bus.cpl_valid) begin
                e = int'(bus.cpl_engine);
                n = bus.cpl_nonce;
                if (e >= NE || exp_cpl[e].size() == 0) begin
                    fail_now("unexpected_completion", $sformatf("engine %0d nonce 0x%08h not finished", e, n));
                end else begin
                    check("completion_nonce", n, exp_cpl[e].pop_front());
                    busy[e] = 1'b0;
                end
                nret++;
                ret_cnt[n] = ret_cnt.exists(n) ? ret_cnt[n] + 1 : 1;
                cpl_eng.push_back(e);
                cpl_cyc.push_back(cyc);
                if (nret == NN) begin
                    check("done_low_at_last_cpl", 32'(done), 32'd0);
                    last_prev = 1'b1;
                end
            end
        end
    endtask

    task automatic start_sweep(input logic [31:0] b);
        int t;
        t = 0;
        while (bus.eng_done !== '1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("engines_idle_timeout", "eng_done never returned high");
        sweep++;
        nret = 0;
        ndisp = 0;
        ret_cnt.delete();
        disp_eng.delete();
        disp_cyc.delete();
        cpl_eng.delete();
        cpl_cyc.delete();
        exp_disp.delete();
        first_disp_seen = 1'b0;
        last_prev = 1'b0;
        cur_base = b;
        for (int i = 0; i < NN; i++) exp_disp.push_back(b + 32'(i));
        @(posedge clk);
        #1 start = 1'b1;
        base_nonce = b;
        @(posedge clk);
        #1 start = 1'b0;
        base_nonce = $urandom();
        e_cyc = cyc;
    endtask

    task automatic wait_sweep(input string name);
        int t;
        logic [31:0] key;
        t = 0;
        while (!(nret >= NN && done) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now(name, "sweep did not complete in time");
        repeat (2) @(negedge clk);
        check("issued_final", 32'(issued), NN);
        check("all_nonces_dispatched", exp_disp.size(), 0);
        check("done_idle", 32'(done), 32'd1);
        for (int i = 0; i < NN; i++) begin
            key = cur_base + 32'(i);
            check("retired_once", ret_cnt.exists(key) ? ret_cnt[key] : 0, 1);
        end
    endtask

    initial begin
        int t, j;
        reset = 1'b1;
        start = 1'b0;
        base_nonce = '0;
        bus.eng_done = '1;
        clear_cfg();
        for (int k = 0; k < NE; k++) busy[k] = 1'b0;
        fork
            forever begin @(posedge clk); cyc++; end
            monitor();
        join_none
        for (int k = 0; k < NE; k++) begin
            automatic int kk = k;
            fork engine_proc(kk); join_none
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_eng_start", 32'(bus.eng_start), 32'd0);
        for (int k = 0; k < NE; k++) check("rst_eng_nonce", bus.eng_nonce[32*k +: 32], 32'd0);
        check("rst_cpl_valid", 32'(bus.cpl_valid), 32'd0);
        check("rst_cpl_engine", 32'(bus.cpl_engine), 32'd0);
        check("rst_cpl_nonce", bus.cpl_nonce, 32'd0);
        check("rst_issued", 32'(issued), 32'd0);
        check("rst_done", 32'(done), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Long-latency engines: first four dispatches fill 0..3 back to back.
        for (int k = 0; k < NE; k++) lat_cfg[k] = 80;
        start_sweep(32'h0000_0010);
        wait_sweep("sweep_long_latency");
        if (disp_eng.size() < 4) fail_now("t1_dispatch_count", "fewer than four dispatches logged");
        else for (int i = 0; i < 4; i++) begin
            check("t1_engine_order", disp_eng[i], i);
            check("t1_consecutive", disp_cyc[i], disp_cyc[0] + i);
        end

        // Engines 1 and 2 finish on the same cycle.
        clear_cfg();
        lat_cfg[0] = 45; lat_cfg[1] = 31; lat_cfg[2] = 30; lat_cfg[3] = 50;
        start_sweep($urandom());
        wait_sweep("sweep_simultaneous");
        j = -1;
        for (int i = 0; i < cpl_eng.size(); i++)
            if (j < 0 && (cpl_eng[i] == 1 || cpl_eng[i] == 2)) j = i;
        if (j < 0 || j + 1 >= cpl_eng.size()) fail_now("t3_pair_missing", "engines 1/2 never retired");
        else begin
            check("t3_first_of_pair", cpl_eng[j], 1);
            check("t3_second_of_pair", cpl_eng[j+1], 2);
            check("t3_pair_adjacent", cpl_cyc[j+1], cpl_cyc[j] + 1);
        end

        clear_cfg();
        start_sweep(32'hFFFF_FFFE);
        wait_sweep("sweep_wrap");

        // Reset with three jobs in flight.
        start_sweep($urandom());
        t = 0;
        while (issued != 16'd3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("t5_reach_three", "issued never reached 3");
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        epoch++;
        exp_disp.delete();
        for (int k = 0; k < NE; k++) begin
            exp_cpl[k].delete();
            busy[k] = 1'b0;
        end
        @(negedge clk);
        check("t5_eng_start", 32'(bus.eng_start), 32'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_issued", 32'(issued), 32'd0);
        check("t5_cpl_valid", 32'(bus.cpl_valid), 32'd0);
        start_sweep($urandom());
        wait_sweep("sweep_after_reset");

        // Late engine 0 and an ignored start mid-sweep.
        clear_cfg();
        late_cfg[0] = 5;
        lat_cfg[0] = 6;
        start_sweep($urandom());
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        base_nonce = 32'hDEAD_0000;
        @(posedge clk);
        #1 start = 1'b0;
        wait_sweep("sweep_late_engine");

        clear_cfg();
        for (int s = 0; s < 4; s++) begin
            start_sweep($urandom());
            wait_sweep("sweep_random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
